// File: rtl/seven_segment_reader_pkg.sv
// rtl/seven_segment_reader_pkg.sv - shared segment encodings, FSM states and counter width
package seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Bit order A..G, MSB first; the encoder side drives exactly these.
    localparam logic [6:0] DIGIT_0 = 7'b1111110;
    localparam logic [6:0] DIGIT_1 = 7'b0110000;
    localparam logic [6:0] DIGIT_2 = 7'b1101101;
    localparam logic [6:0] DIGIT_3 = 7'b1111001;
    localparam logic [6:0] DIGIT_4 = 7'b0110011;
    localparam logic [6:0] DIGIT_5 = 7'b1011011;
    localparam logic [6:0] DIGIT_6 = 7'b1011111;
    localparam logic [6:0] DIGIT_7 = 7'b1110000;
    localparam logic [6:0] DIGIT_8 = 7'b1111111;
    localparam logic [6:0] DIGIT_9 = 7'b1111011;

    localparam int CNT_W = 20;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_STABLE
    } state_t;

endpackage

// File: rtl/seven_segment_reader_decode.sv
// rtl/seven_segment_reader_decode.sv - combinational seven-segment pattern to decimal digit
module seven_segment_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            DIGIT_0: digit = 4'd0;
            DIGIT_1: digit = 4'd1;
            DIGIT_2: digit = 4'd2;
            DIGIT_3: digit = 4'd3;
            DIGIT_4: digit = 4'd4;
            DIGIT_5: digit = 4'd5;
            DIGIT_6: digit = 4'd6;
            DIGIT_7: digit = 4'd7;
            DIGIT_8: digit = 4'd8;
            DIGIT_9: digit = 4'd9;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - debounced two-digit seven-segment value recovery with step classification
module seven_segment_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 250000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Seg1,
    input  logic [6:0] i_Seg2,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic [6:0] o_Value,
    output logic       o_Valid,
    output logic       o_Step_Up,
    output logic       o_Step_Down,
    output logic       o_Jump,
    output logic       o_Invalid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [13:0]      seg_in;
    logic [13:0]      r_raw;
    logic [13:0]      r_raw_d;
    logic [13:0]      r_commit;
    logic             r_have_commit;
    logic             r_have_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] cnt_next;
    state_t           r_state;

    logic [3:0] tens_dec;
    logic [3:0] ones_dec;
    logic       tens_ok;
    logic       ones_ok;
    logic [6:0] new_value;
    logic [6:0] prev_plus;
    logic [6:0] prev_minus;

    assign seg_in = SEG_ACTIVE_LOW ? ~{i_Seg1, i_Seg2} : {i_Seg1, i_Seg2};

    seven_segment_decode u_dec_tens (
        .seg   (r_raw[13:7]),
        .digit (tens_dec),
        .ok    (tens_ok)
    );

    seven_segment_decode u_dec_ones (
        .seg   (r_raw[6:0]),
        .digit (ones_dec),
        .ok    (ones_ok)
    );

    assign new_value  = 7'({tens_dec, 3'b000}) + 7'({tens_dec, 1'b0}) + 7'(ones_dec);
    assign prev_plus  = (o_Value == 7'd99) ? 7'd0  : o_Value + 7'd1;
    assign prev_minus = (o_Value == 7'd0)  ? 7'd99 : o_Value - 7'd1;

    always_comb begin
        cnt_next = r_cnt;
        if (r_raw != r_raw_d)
            cnt_next = '0;
        else if (r_cnt != CNT_MAX)
            cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_raw         <= '0;
            r_raw_d       <= '0;
            r_commit      <= '0;
            r_have_commit <= 1'b0;
            r_have_prev   <= 1'b0;
            r_cnt         <= '0;
            r_state       <= S_WAIT;
            o_Tens        <= '0;
            o_Ones        <= '0;
            o_Value       <= '0;
            o_Valid       <= 1'b0;
            o_Step_Up     <= 1'b0;
            o_Step_Down   <= 1'b0;
            o_Jump        <= 1'b0;
            o_Invalid     <= 1'b0;
        end else begin
            r_raw       <= seg_in;
            r_raw_d     <= r_raw;
            r_cnt       <= cnt_next;
            o_Valid     <= 1'b0;
            o_Step_Up   <= 1'b0;
            o_Step_Down <= 1'b0;
            o_Jump      <= 1'b0;
            case (r_state)
                S_WAIT: r_state <= S_SETTLE;
                S_SETTLE: begin
                    if (cnt_next == CNT_MAX) begin
                        r_state       <= S_STABLE;
                        r_commit      <= r_raw;
                        r_have_commit <= 1'b1;
                        // A glitch that settles back onto the committed pattern is silent.
                        if (!(r_have_commit && r_raw == r_commit)) begin
                            if (tens_ok && ones_ok) begin
                                o_Tens      <= tens_dec;
                                o_Ones      <= ones_dec;
                                o_Value     <= new_value;
                                o_Valid     <= 1'b1;
                                o_Invalid   <= 1'b0;
                                r_have_prev <= 1'b1;
                                if (r_have_prev) begin
                                    o_Step_Up   <= (new_value == prev_plus);
                                    o_Step_Down <= (new_value == prev_minus);
                                    o_Jump      <= (new_value != prev_plus) &&
                                                   (new_value != prev_minus) &&
                                                   (new_value != o_Value);
                                end
                            end else begin
                                o_Invalid <= 1'b1;
                            end
                        end
                    end
                end
                S_STABLE: begin
                    if (r_raw != r_commit) begin
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - scoreboard bench for seven_segment_reader
module tb_seven_segment_reader;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [6:0] seg1, seg2, seg1_n, seg2_n;

    logic [3:0] o_Tens, o_Ones, lo_Tens, lo_Ones;
    logic [6:0] o_Value, lo_Value;
    logic       o_Valid, o_Step_Up, o_Step_Down, o_Jump, o_Invalid;
    logic       lo_Valid, lo_Step_Up, lo_Step_Down, lo_Jump, lo_Invalid;

    always #5 i_Clk = ~i_Clk;

    seven_segment_reader #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Seg1(seg1), .i_Seg2(seg2),
        .o_Tens(o_Tens), .o_Ones(o_Ones), .o_Value(o_Value), .o_Valid(o_Valid),
        .o_Step_Up(o_Step_Up), .o_Step_Down(o_Step_Down), .o_Jump(o_Jump),
        .o_Invalid(o_Invalid)
    );

    seven_segment_reader #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Seg1(seg1_n), .i_Seg2(seg2_n),
        .o_Tens(lo_Tens), .o_Ones(lo_Ones), .o_Value(lo_Value), .o_Valid(lo_Valid),
        .o_Step_Up(lo_Step_Up), .o_Step_Down(lo_Step_Down), .o_Jump(lo_Jump),
        .o_Invalid(lo_Invalid)
    );

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] v;
        logic       up;
        logic       dn;
        logic       jp;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_valid_lo = 0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b1111110;
            1: enc = 7'b0110000;
            2: enc = 7'b1101101;
            3: enc = 7'b1111001;
            4: enc = 7'b0110011;
            5: enc = 7'b1011011;
            6: enc = 7'b1011111;
            7: enc = 7'b1110000;
            8: enc = 7'b1111111;
            default: enc = 7'b1111011;
        endcase
    endfunction

    always @(negedge i_Clk) begin
        exp_t e;
        if (!i_Reset) begin
            n_assert++;
            assert (!((o_Step_Up | o_Step_Down | o_Jump) && !o_Valid) &&
                    $onehot0({o_Step_Up, o_Step_Down, o_Jump}))
            else begin
                n_fail++;
                $error("FAIL flag_exclusive observed=%b%b%b valid=%b expected onehot0 with valid",
                       o_Step_Up, o_Step_Down, o_Jump, o_Valid);
            end
            if (o_Valid) begin
                n_valid++;
                n_assert++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_valid observed value=%0d expected no strobe", o_Value);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_assert++;
                    assert ({o_Tens, o_Ones, o_Value, o_Step_Up, o_Step_Down, o_Jump} === e)
                    else begin
                        n_fail++;
                        $error("FAIL strobe observed t=%0d o=%0d v=%0d u/d/j=%b%b%b expected t=%0d o=%0d v=%0d u/d/j=%b%b%b",
                               o_Tens, o_Ones, o_Value, o_Step_Up, o_Step_Down, o_Jump,
                               e.t, e.o, e.v, e.up, e.dn, e.jp);
                    end
                end
            end
            if (lo_Valid) n_valid_lo++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic show(input int t, input int o);
        seg1 = enc(t);
        seg2 = enc(o);
    endtask

    task automatic push(input int t, input int o, input logic up, input logic dn, input logic jp);
        exp_t e;
        e.t = 4'(t); e.o = 4'(o); e.v = 7'(t * 10 + o);
        e.up = up; e.dn = dn; e.jp = jp;
        q.push_back(e);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge i_Clk);
        check(tag, q.size(), 0);
        q.delete();
        cyc(2);
    endtask

    initial begin
        int v0;
        int edges;
        i_Reset = 1'b1;
        show(4, 2);
        seg1_n = 7'h7f;
        seg2_n = 7'h7f;
        cyc(3);
        check("reset_outputs", int'({o_Tens, o_Ones, o_Value, o_Valid, o_Step_Up,
                                     o_Step_Down, o_Jump, o_Invalid}), 0);

        v0 = n_valid;
        push(4, 2, 0, 0, 0);
        i_Reset = 1'b0;
        drain("first_42");
        cyc(10);
        check("first_valid_once", n_valid - v0, 1);
        check("first_invalid", int'(o_Invalid), 0);

        show(4, 3);
        push(4, 3, 1, 0, 0);
        edges = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_Clk);
            #1;
            edges++;
            if (o_Valid) break;
        end
        check("latency_43", edges, 5);
        drain("up_43");

        show(9, 9); push(9, 9, 0, 0, 1); drain("jump_99");
        show(0, 0); push(0, 0, 1, 0, 0); drain("wrap_up_00");
        show(9, 9); push(9, 9, 0, 1, 0); drain("wrap_down_99");
        show(5, 5); push(5, 5, 0, 0, 1); drain("jump_55");
        show(4, 2); push(4, 2, 0, 0, 1); drain("jump_42");

        v0 = n_valid;
        show(4, 3);
        cyc(3);
        show(4, 2);
        cyc(15);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_value", int'(o_Value), 42);

        v0 = n_valid;
        seg2 = 7'b0000000;
        cyc(10);
        check("blank_invalid", int'(o_Invalid), 1);
        check("blank_value_hold", int'(o_Value), 42);
        check("blank_no_valid", n_valid - v0, 0);
        show(4, 2);
        push(4, 2, 0, 0, 0);
        drain("restore_42");
        check("restore_invalid", int'(o_Invalid), 0);

        show(4, 3);
        cyc(2);
        i_Reset = 1'b1;
        cyc(1);
        check("midreset_outputs", int'({o_Tens, o_Ones, o_Value, o_Valid, o_Step_Up,
                                        o_Step_Down, o_Jump, o_Invalid}), 0);
        push(4, 3, 0, 0, 0);
        i_Reset = 1'b0;
        drain("post_reset_43");
        check("post_reset_value", int'(o_Value), 43);

        v0 = n_valid_lo;
        seg1_n = ~enc(0);
        seg2_n = ~enc(7);
        cyc(12);
        check("lo_valid_once", n_valid_lo - v0, 1);
        check("lo_value", int'(lo_Value), 7);
        check("lo_invalid", int'(lo_Invalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
